// File: rtl/audio_dac_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : audio_dac_tx_if
// Description : Sample handshake and serial codec pins for audio_dac_tx.
// Revision    : 1.0 - initial release
// ============================================================================
interface audio_dac_tx_if;
    logic [15:0] left_data;
    logic [15:0] right_data;
    logic        data_valid;
    logic        data_ready;
    logic        bclk;
    logic        lrclk;
    logic        dacdat;
    logic        underrun;

    // Sample source side.
    modport master (
        output left_data,
        output right_data,
        output data_valid,
        input  data_ready,
        input  bclk,
        input  lrclk,
        input  dacdat,
        input  underrun
    );

    // Transmitter side.
    modport slave (
        input  left_data,
        input  right_data,
        input  data_valid,
        output data_ready,
        output bclk,
        output lrclk,
        output dacdat,
        output underrun
    );
endinterface
`default_nettype wire

// File: rtl/audio_dac_tx.sv
`default_nettype none
// ============================================================================
// Module      : audio_dac_tx
// Description : I2S stereo DAC transmitter, 16-bit samples in 32-bit frames,
//               single-entry holding buffer with underrun repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_dac_tx #(
    parameter int BCLK_DIV = 4
) (
    input  wire logic    clk,
    input  wire logic    reset,
    audio_dac_tx_if.slave dac_if
);

    localparam logic [7:0] c_DIV_LAST  = 8'(BCLK_DIV - 1);
    localparam logic [4:0] c_SLOT_LAST = 5'd31;

    logic [7:0]  r_div_cnt;
    logic        r_bclk;
    logic [4:0]  r_slot;
    logic        r_lrclk;
    logic        r_dacdat;
    logic [31:0] r_shift;
    logic [31:0] r_last;
    logic [31:0] r_buf;
    logic        r_data_ready;
    logic        r_underrun;

    logic        w_wrap;
    logic        w_fall;
    logic        w_load;
    logic        w_accept;
    logic [4:0]  w_next_slot;
    logic [31:0] w_load_word;

    assign w_wrap      = (r_div_cnt == c_DIV_LAST);
    assign w_fall      = w_wrap && r_bclk;
    assign w_load      = w_fall && (r_slot == c_SLOT_LAST);
    assign w_accept    = dac_if.data_valid && r_data_ready;
    assign w_next_slot = r_slot + 5'd1;
    // A full buffer feeds the new frame; an empty one repeats the last frame.
    assign w_load_word = r_data_ready ? r_last : r_buf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= 8'd0;
            r_bclk    <= 1'b0;
        end else if (w_wrap) begin
            r_div_cnt <= 8'd0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
        end
    end

    // Sending r_shift[31] before shifting gives the one-bit I2S delay: the
    // previous frame's final bit lands in slot 0 as the new word is loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot   <= c_SLOT_LAST;
            r_lrclk  <= 1'b0;
            r_dacdat <= 1'b0;
            r_shift  <= 32'd0;
            r_last   <= 32'd0;
        end else if (w_fall) begin
            r_slot   <= w_next_slot;
            r_lrclk  <= w_next_slot[4];
            r_dacdat <= r_shift[31];
            if (w_load) begin
                r_shift <= w_load_word;
                r_last  <= w_load_word;
            end else begin
                r_shift <= {r_shift[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf        <= 32'd0;
            r_data_ready <= 1'b1;
            r_underrun   <= 1'b0;
        end else begin
            r_underrun <= w_load && r_data_ready;
            if (w_accept) begin
                r_buf        <= {dac_if.left_data, dac_if.right_data};
                r_data_ready <= 1'b0;
            end else if (w_load) begin
                r_data_ready <= 1'b1;
            end
        end
    end

    assign dac_if.data_ready = r_data_ready;
    assign dac_if.bclk       = r_bclk;
    assign dac_if.lrclk      = r_lrclk;
    assign dac_if.dacdat     = r_dacdat;
    assign dac_if.underrun   = r_underrun;

endmodule
`default_nettype wire

// File: doc/audio_dac_tx.md
AUDIO_DAC_TX -- requirements
Module: audio_dac_tx

Interface
REQ-001 Parameter BCLK_DIV, default 4: clk cycles per bclk half-period; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 left_data  input  16  signed left-channel sample, two's complement.
REQ-005 right_data  input  16  signed right-channel sample, two's complement.
REQ-006 data_valid  input  1  source offers left_data/right_data this cycle.
REQ-007 data_ready  output  1  single-entry holding buffer empty; a word is accepted when data_valid && data_ready.
REQ-008 bclk  output  1  serial bit clock to the codec.
REQ-009 lrclk  output  1  channel select: 0 = left, 1 = right.
REQ-010 dacdat  output  1  serial sample data to the codec, I2S format.
REQ-011 underrun  output  1  one-clk pulse when a frame starts with the holding buffer empty.

Function
REQ-012 The divider counter shall count 0..BCLK_DIV-1 and wrap; on the wrap cycle bclk shall toggle.
- Rising event: bclk toggles 0->1.
- Falling event: bclk toggles 1->0.
REQ-013 A slot counter shall advance modulo 32 on each falling event; slot 0 starts a frame; a frame is 32 bclk periods.
REQ-014 lrclk shall update on each falling event to 1 when the new slot is 16..31, else 0.
REQ-015 At the falling event entering slot 0, a 32-bit shift register shall load {left, right}:
- from the holding buffer if it is full, and the buffer is marked empty;
- otherwise from the last frame sent, with underrun pulsed that cycle.
REQ-016 dacdat shall update only on falling events, with a one-bit I2S delay:
- slot 0: the LSB of the previous frame's right word;
- slot s = 1..31: bit (32-s) of the current 32-bit frame word.
- Left MSB is sent in slot 1; right MSB in slot 17; right LSB in slot 0 of the next frame.
REQ-017 data_ready shall be 1 exactly when the holding buffer is empty, as a registered output.
REQ-018 On an accept, the holding buffer shall capture left_data/right_data, and data_ready shall be 0 from the next cycle.
REQ-019 data_valid while data_ready=0 shall be ignored, and buffer contents shall be unchanged.
REQ-020 Frame load and accept in the same cycle (possible only with the buffer empty at the load):
- the load shall use the last frame and pulse underrun;
- the accepted word shall enter the buffer for the next frame.
REQ-021 Frame load from a full buffer shall raise data_ready on the following cycle.
REQ-022 The block shall have no gap or stall mode: bclk, lrclk and dacdat shall run continuously whenever reset=0.

Reset
REQ-023 While reset=1, the block shall hold:
- bclk=0, lrclk=0, dacdat=0, underrun=0, data_ready=1;
- divider counter=0, slot counter=31;
- shift register and last-frame register=0, holding buffer empty.
REQ-024 After reset deassertion, the first falling event shall enter slot 0 and load a frame per REQ-015.
- Without a preceding accept, this load shall be zeros and underrun shall pulse.
REQ-025 Reset asserted mid-frame shall take effect on the next clk edge.
- Any partial frame and any buffered word shall be discarded.
- No falling event shall be generated by the reset itself.

Verification (BCLK_DIV=2: bclk period 4 clk, frame 128 clk)
REQ-026 Release reset with no input.
- bclk first rises 2 clk after release and first falls 4 clk after release.
- underrun pulses once per frame.
- dacdat=0 throughout.
REQ-027 Accept left=16'h8001, right=16'h7FFE before the first frame.
- Sampling dacdat at bclk rising edges, slots 1..16 give 1000_0000_0000_0001.
- Slots 17..31 plus the next slot 0 give 0111_1111_1111_1110.
- lrclk=1 for slots 16..31.
REQ-028 Hold data_valid=1 with new words each cycle.
- Exactly one word is accepted per frame.
- data_ready is low for the rest of the frame after each accept.
- Each accepted word appears in order, with no underrun after the first frame.
REQ-029 Send one word 16'h1234/16'hABCD, then stop.
- The following frames repeat 1234/ABCD.
- underrun pulses at each of those frame starts.
REQ-030 Assert data_valid exactly on the slot-0 load cycle with the buffer empty.
- underrun pulses and the old frame is sent.
- The new word is sent in the next frame.
REQ-031 Assert reset at slot 20 for 1 clk.
- All outputs return to their REQ-023 values.
- A buffered word is lost, and the next frame transmits zeros.
